// File: rtl/imm_extend_stage.sv
// Immediate extender between decode and execute.
// Output register plus one skid entry, so execute-stage stalls never lose a word.
module imm_extend_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INSTR_W  = 24,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [2:0]         in_immtype,
    input  logic               in_cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_carry,
    output logic               out_illegal,
    output logic               err_sticky
);

    localparam int unsigned ROT_W = 5;

    if (INSTR_W != 24) begin : g_bad_instr_w
        $error("imm_extend_stage: INSTR_W must be 24");
    end
    if (DATA_W < 26 || DATA_W > 64) begin : g_bad_data_w
        $error("imm_extend_stage: DATA_W must be in 26..64");
    end
    if (BR_SHIFT > DATA_W - 24) begin : g_bad_br_shift
        $error("imm_extend_stage: BR_SHIFT must not exceed DATA_W-24");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;

    logic [DATA_W-1:0] skid_data;
    logic              skid_carry;
    logic              skid_illegal;

    logic [DATA_W-1:0] ext_data_c;
    logic              ext_carry_c;
    logic              ext_illegal_c;
    logic [DATA_W-1:0] rot_src_c;
    logic [ROT_W-1:0]  rot_c;
    logic              in_fire_c;
    logic              out_fire_c;

    // Reset forces ready high; anything offered during reset is dropped below.
    assign in_ready   = reset | (state != FULL);
    assign out_valid  = (state != EMPTY);
    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Immediate decode, purely combinational on the offered instruction.
    always_comb begin
        ext_data_c    = '0;
        ext_carry_c   = 1'b0;
        ext_illegal_c = 1'b0;
        rot_src_c     = DATA_W'(in_instr[7:0]);
        rot_c         = {in_instr[11:8], 1'b0};
        case (in_immtype)
            3'b000: ext_data_c = DATA_W'(in_instr[7:0]);
            3'b001: ext_data_c = DATA_W'(in_instr[11:0]);
            3'b010: ext_data_c = {{(DATA_W-24){in_instr[23]}}, in_instr[23:0]} << BR_SHIFT;
            3'b011: begin
                ext_data_c  = DATA_W'({rot_src_c, rot_src_c} >> rot_c);
                ext_carry_c = (rot_c != '0) ? ext_data_c[DATA_W-1] : in_cin;
            end
            3'b100: ext_data_c = {{(DATA_W-12){in_instr[11]}}, in_instr[11:0]};
            default: ext_illegal_c = 1'b1;
        endcase
    end

    // Skid-buffer FSM with registered payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= EMPTY;
            out_data     <= '0;
            out_carry    <= 1'b0;
            out_illegal  <= 1'b0;
            skid_data    <= '0;
            skid_carry   <= 1'b0;
            skid_illegal <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            if (in_fire_c && ext_illegal_c) begin
                err_sticky <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (in_fire_c) begin
                        out_data    <= ext_data_c;
                        out_carry   <= ext_carry_c;
                        out_illegal <= ext_illegal_c;
                        state       <= HALF;
                    end
                end
                HALF: begin
                    if (in_fire_c && out_fire_c) begin
                        out_data    <= ext_data_c;
                        out_carry   <= ext_carry_c;
                        out_illegal <= ext_illegal_c;
                    end else if (in_fire_c) begin
                        skid_data    <= ext_data_c;
                        skid_carry   <= ext_carry_c;
                        skid_illegal <= ext_illegal_c;
                        state        <= FULL;
                    end else if (out_fire_c) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire_c) begin
                        out_data    <= skid_data;
                        out_carry   <= skid_carry;
                        out_illegal <= skid_illegal;
                        state       <= HALF;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed-vector bench for imm_extend_stage with hand-computed expectations.
module tb_imm_extend_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic [2:0]  in_immtype;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_illegal;
    logic        err_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_extend_stage #(.DATA_W(32), .INSTR_W(24), .BR_SHIFT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_immtype (in_immtype),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_carry  (out_carry),
        .out_illegal(out_illegal),
        .err_sticky (err_sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] t, input logic [23:0] i, input logic c);
        in_valid   = 1'b1;
        in_immtype = t;
        in_instr   = i;
        in_cin     = c;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic c, input logic il);
        check({tag, ".valid"},   64'(out_valid),   64'd1);
        check({tag, ".data"},    64'(out_data),    64'(d));
        check({tag, ".carry"},   64'(out_carry),   64'(c));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(il));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_immtype = '0;
        in_cin = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("rst.valid",  64'(out_valid),  64'd0);
        check("rst.data",   64'(out_data),   64'd0);
        check("rst.ready",  64'(in_ready),   64'd1);
        check("rst.sticky", 64'(err_sticky), 64'd0);
        reset = 1'b0;
        tick();

        offer(3'b000, 24'h0000A5, 1'b0);
        tick();
        expect_word("zero8", 32'h000000A5, 1'b0, 1'b0);

        offer(3'b010, 24'hFFFFFE, 1'b0);
        tick();
        expect_word("br_neg", 32'hFFFFFFF8, 1'b0, 1'b0);
        offer(3'b010, 24'h000001, 1'b0);
        tick();
        expect_word("br_pos", 32'h00000004, 1'b0, 1'b0);

        offer(3'b011, 24'h0004FF, 1'b0);
        tick();
        expect_word("rot8_8", 32'hFF000000, 1'b1, 1'b0);
        offer(3'b011, 24'h0000FF, 1'b1);
        tick();
        expect_word("rot8_0_cin1", 32'h000000FF, 1'b1, 1'b0);
        offer(3'b011, 24'h0000FF, 1'b0);
        tick();
        expect_word("rot8_0_cin0", 32'h000000FF, 1'b0, 1'b0);
        offer(3'b011, 24'h000101, 1'b1);
        tick();
        expect_word("rot8_2", 32'h40000000, 1'b0, 1'b0);
        offer(3'b011, 24'h0001FF, 1'b0);
        tick();
        expect_word("rot8_2b", 32'hC000003F, 1'b1, 1'b0);

        offer(3'b100, 24'h000800, 1'b0);
        tick();
        expect_word("sext12", 32'hFFFFF800, 1'b0, 1'b0);
        offer(3'b001, 24'h000800, 1'b0);
        tick();
        expect_word("zero12", 32'h00000800, 1'b0, 1'b0);
        offer(3'b000, 24'hFFFFFF, 1'b0);
        tick();
        expect_word("zero8_hi", 32'h000000FF, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: A, B, C offered while the consumer stalls.
        out_ready = 1'b0;
        offer(3'b000, 24'h000011, 1'b0);
        tick();
        expect_word("bp.A", 32'h11, 1'b0, 1'b0);
        check("bp.ready_half", 64'(in_ready), 64'd1);
        offer(3'b000, 24'h000022, 1'b0);
        tick();
        expect_word("bp.A_hold", 32'h11, 1'b0, 1'b0);
        check("bp.ready_full", 64'(in_ready), 64'd0);
        offer(3'b000, 24'h000033, 1'b0);
        tick();
        expect_word("bp.A_hold2", 32'h11, 1'b0, 1'b0);
        check("bp.ready_full2", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        expect_word("bp.B", 32'h22, 1'b0, 1'b0);
        check("bp.ready_after", 64'(in_ready), 64'd1);
        tick();
        expect_word("bp.C", 32'h33, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        check("bp.empty", 64'(out_valid), 64'd0);

        offer(3'b111, 24'hFFFFFF, 1'b1);
        tick();
        expect_word("ill7", 32'h0, 1'b0, 1'b1);
        check("ill7.sticky", 64'(err_sticky), 64'd1);
        offer(3'b101, 24'h0004FF, 1'b1);
        tick();
        expect_word("ill5", 32'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick();
        check("ill.consumed", 64'(out_valid),  64'd0);
        check("ill.sticky_kept", 64'(err_sticky), 64'd1);

        // Fill to FULL, then reset mid-transfer with input still offered.
        out_ready = 1'b0;
        offer(3'b000, 24'h000044, 1'b0);
        tick();
        offer(3'b000, 24'h000055, 1'b0);
        tick();
        check("full.ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("rstfull.ready_comb", 64'(in_ready), 64'd1);
        tick();
        check("rstfull.valid",  64'(out_valid),   64'd0);
        check("rstfull.data",   64'(out_data),    64'd0);
        check("rstfull.ill",    64'(out_illegal), 64'd0);
        check("rstfull.sticky", 64'(err_sticky),  64'd0);
        check("rstfull.ready",  64'(in_ready),    64'd1);
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst.discard", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
